// File: rtl/idli_sqi_s.sv
// SQI memory responder: device end of the nibble-wide SQI link.
// Models one byte-addressable memory in sequential mode. SCK is sampled
// on the global clock and edge-detected; captures happen on SCK rise,
// output updates happen on SCK fall.

package idli_sqi_pkg;
    typedef logic [3:0] sqi_data_t;
endpackage

module idli_sqi_s
    import idli_sqi_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [7:0]  CMD_READ   = 8'h03,
    parameter logic [7:0]  CMD_WRITE  = 8'h02
) (
    input  logic      i_sqi_gck,
    input  logic      i_sqi_rst_n,
    input  logic      i_sqi_sck,
    input  logic      i_sqi_cs,
    input  sqi_data_t i_sqi_sio,
    output sqi_data_t o_sqi_sio,
    output logic      o_sqi_oe
);

    typedef enum logic [2:0] {
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    typedef logic [DEPTH_LOG2-1:0] addr_t;

    logic       sck_q;
    state_t     state;
    logic [2:0] cnt;        // rises seen within the current state
    sqi_data_t  hold;       // high nibble of instruction / write byte
    logic       is_read;
    logic       rd_lo;      // next fall in RDATA drives the low nibble
    addr_t      addr;

    logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic       rise;
    logic       fall;
    logic       wr_en;
    logic [7:0] rd_byte;

    // A deselected cycle swallows any SCK edge seen in that cycle.
    assign rise    = i_sqi_sck & ~sck_q & ~i_sqi_cs;
    assign fall    = ~i_sqi_sck & sck_q & ~i_sqi_cs;
    assign rd_byte = mem[addr];
    assign wr_en   = rise && (state == ST_WDATA) && (cnt == 3'd1);

    // Delayed SCK for edge detection.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= i_sqi_sck;
        end
    end

    // Transaction FSM: captures on rise, drives read data on fall.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state     <= ST_INSTR;
            cnt       <= 3'd0;
            hold      <= '0;
            is_read   <= 1'b0;
            rd_lo     <= 1'b0;
            addr      <= '0;
            o_sqi_sio <= '0;
            o_sqi_oe  <= 1'b0;
        end else if (i_sqi_cs) begin
            // Deselect aborts whatever was in flight, including a
            // half-received write byte still sitting in hold.
            state    <= ST_INSTR;
            cnt      <= 3'd0;
            o_sqi_oe <= 1'b0;
        end else if (rise) begin
            case (state)
                ST_INSTR: begin
                    if (cnt == 3'd0) begin
                        hold <= i_sqi_sio;
                        cnt  <= 3'd1;
                    end else begin
                        cnt <= 3'd0;
                        if ({hold, i_sqi_sio} == CMD_READ) begin
                            is_read <= 1'b1;
                            state   <= ST_ADDR;
                        end else if ({hold, i_sqi_sio} == CMD_WRITE) begin
                            is_read <= 1'b0;
                            state   <= ST_ADDR;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    // Shifting all six nibbles through a DEPTH_LOG2-wide
                    // register leaves only the low address bits behind.
                    addr <= (addr << 4) | addr_t'(i_sqi_sio);
                    if (cnt == 3'd5) begin
                        cnt   <= 3'd0;
                        state <= is_read ? ST_DUMMY : ST_WDATA;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_DUMMY: begin
                    if (cnt == 3'd1) begin
                        cnt   <= 3'd0;
                        rd_lo <= 1'b0;
                        state <= ST_RDATA;
                    end else begin
                        cnt <= 3'd1;
                    end
                end
                ST_WDATA: begin
                    if (cnt == 3'd0) begin
                        hold <= i_sqi_sio;
                        cnt  <= 3'd1;
                    end else begin
                        // Byte lands in storage this cycle via wr_en.
                        cnt  <= 3'd0;
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (fall && state == ST_RDATA) begin
            o_sqi_oe <= 1'b1;
            if (!rd_lo) begin
                o_sqi_sio <= rd_byte[7:4];
                rd_lo     <= 1'b1;
            end else begin
                o_sqi_sio <= rd_byte[3:0];
                rd_lo     <= 1'b0;
                addr      <= addr + 1'b1;
            end
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge i_sqi_gck) begin
        if (wr_en) begin
            mem[addr] <= {hold, i_sqi_sio};
        end
    end

endmodule

// File: tb/tb_idli_sqi_s.sv
// Bench for idli_sqi_s: table of directed transactions, hand-written
// corner sequences, then random reads/writes against a byte-array model.

module tb_idli_sqi_s;
    import idli_sqi_pkg::*;

    logic      gck   = 1'b0;
    logic      rst_n = 1'b0;
    logic      sck   = 1'b0;
    logic      cs    = 1'b1;
    sqi_data_t sio_in = '0;
    sqi_data_t sio_out;
    logic      oe;

    idli_sqi_s #(.DEPTH_LOG2(8)) dut (
        .i_sqi_gck  (gck),
        .i_sqi_rst_n(rst_n),
        .i_sqi_sck  (sck),
        .i_sqi_cs   (cs),
        .i_sqi_sio  (sio_in),
        .o_sqi_sio  (sio_out),
        .o_sqi_oe   (oe)
    );

    always #5 gck = ~gck;

    int total = 0;
    int bad   = 0;

    // Reference memory: plain bytes, address modulo 256.
    logic [7:0] mdl [256];

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        int          nnib;
        logic [15:0] val;   // nibbles right-aligned, first nibble highest
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One SCK period: fall with new data, then rise; sample after the rise.
    task automatic nib(input logic [3:0] n, output logic [3:0] so, output logic soe);
        @(negedge gck); sck = 1'b0; sio_in = n;
        @(negedge gck);
        @(negedge gck); sck = 1'b1;
        @(negedge gck); so = sio_out; soe = oe;
    endtask

    task automatic nib_tx(input logic [3:0] n);
        logic [3:0] so;
        logic       soe;
        nib(n, so, soe);
    endtask

    task automatic start_cs();
        @(negedge gck); cs = 1'b0; sck = 1'b0;
    endtask

    task automatic end_cs();
        @(negedge gck); cs = 1'b1; sck = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
        nib_tx(cmd[7:4]);
        nib_tx(cmd[3:0]);
        for (int i = 5; i >= 0; i--) nib_tx(a[i*4 +: 4]);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [7:0] b[$]);
        start_cs();
        hdr(8'h02, a);
        for (int i = 0; i < b.size(); i++) begin
            nib_tx(b[i][7:4]);
            nib_tx(b[i][3:0]);
            mdl[8'(a + 24'(i))] = b[i];
        end
        end_cs();
    endtask

    task automatic do_read(input string nm, input logic [23:0] a, input int nbytes,
                           output logic [3:0] got[$]);
        logic [3:0] so;
        logic       soe;
        got = {};
        start_cs();
        hdr(8'h03, a);
        nib(4'($urandom), so, soe);
        nib(4'($urandom), so, soe);
        chk({nm, "_dummy_oe"}, 32'(soe), 32'd0);
        for (int i = 0; i < nbytes * 2; i++) begin
            nib(4'($urandom), so, soe);
            chk({nm, "_oe"}, 32'(soe), 32'd1);
            got.push_back(so);
        end
        end_cs();
    endtask

    initial begin
        logic [7:0] q[$];
        logic [3:0] got[$];
        logic [3:0] so;
        logic       soe;

        tbl[0] = '{1'b1, 24'h000010, 4, 16'hA53C};
        tbl[1] = '{1'b0, 24'h000010, 4, 16'hA53C};
        tbl[2] = '{1'b1, 24'h0000FF, 4, 16'h1122};
        tbl[3] = '{1'b0, 24'h000000, 2, 16'h0022};
        tbl[4] = '{1'b0, 24'h0000FF, 4, 16'h1122};
        tbl[5] = '{1'b1, 24'h000040, 2, 16'h0077};
        tbl[6] = '{1'b0, 24'hABCD40, 2, 16'h0077};

        // Reset state
        repeat (3) @(negedge gck);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_sio", 32'(sio_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge gck);

        // Fill storage so every byte is known to the model
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        do_write(24'h0, q);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) begin
                q = {};
                for (int j = 0; j < tbl[i].nnib / 2; j++)
                    q.push_back(8'(tbl[i].val >> (8 * (tbl[i].nnib / 2 - 1 - j))));
                do_write(tbl[i].addr, q);
            end else begin
                do_read($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].nnib / 2, got);
                for (int k = 0; k < tbl[i].nnib; k++)
                    chk($sformatf("tbl%0d_nib%0d", i, k), 32'(got[k]),
                        32'(4'(tbl[i].val >> (4 * (tbl[i].nnib - 1 - k)))));
            end
        end

        // Abort after one data nibble leaves storage unchanged
        start_cs();
        hdr(8'h02, 24'h000040);
        nib_tx(4'h9);
        end_cs();
        do_read("abort", 24'h40, 1, got);
        chk("abort_hi", 32'(got[0]), 32'h7);
        chk("abort_lo", 32'(got[1]), 32'h7);

        // Unknown instruction: responder stays silent
        start_cs();
        nib(4'hF, so, soe); chk("unk_oe_i0", 32'(soe), 32'd0);
        nib(4'hF, so, soe); chk("unk_oe_i1", 32'(soe), 32'd0);
        for (int i = 0; i < 12; i++) begin
            nib(4'($urandom), so, soe);
            chk($sformatf("unk_oe_%0d", i), 32'(soe), 32'd0);
        end
        end_cs();
        do_read("unk_after", 24'h10, 2, got);
        chk("unk_after0", 32'(got[0]), 32'hA);
        chk("unk_after1", 32'(got[1]), 32'h5);
        chk("unk_after2", 32'(got[2]), 32'h3);
        chk("unk_after3", 32'(got[3]), 32'hC);

        // CS deasserts in the same cycle as the 2nd data rise
        start_cs();
        hdr(8'h02, 24'h000040);
        nib_tx(4'h1);
        @(negedge gck); sck = 1'b0; sio_in = 4'h2;
        @(negedge gck);
        @(negedge gck); sck = 1'b1; cs = 1'b1;
        @(negedge gck);
        @(negedge gck); sck = 1'b0;
        repeat (2) @(negedge gck);
        do_read("simcs", 24'h40, 1, got);
        chk("simcs_hi", 32'(got[0]), 32'h7);
        chk("simcs_lo", 32'(got[1]), 32'h7);

        // Async reset in the middle of read data
        start_cs();
        hdr(8'h03, 24'h000010);
        nib_tx(4'h0);
        nib_tx(4'h0);
        nib(4'h0, so, soe); chk("rr_d0", 32'(so), 32'hA);
        nib(4'h0, so, soe); chk("rr_d1", 32'(so), 32'h5);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_async_oe", 32'(oe), 32'd0);
        chk("rr_async_sio", 32'(sio_out), 32'd0);
        sck = 1'b0; cs = 1'b1;
        repeat (2) @(negedge gck);
        rst_n = 1'b1;
        repeat (2) @(negedge gck);
        do_read("rr_after", 24'h10, 2, got);
        chk("rr_after0", 32'(got[0]), 32'hA);
        chk("rr_after1", 32'(got[1]), 32'h5);
        chk("rr_after2", 32'(got[2]), 32'h3);
        chk("rr_after3", 32'(got[3]), 32'hC);

        // Random traffic against the byte model
        for (int t = 0; t < 40; t++) begin
            logic [23:0] a;
            int          n;
            int          kind;
            a    = 24'($urandom);
            kind = int'($urandom_range(0, 4));
            if (kind < 2) begin
                n = int'($urandom_range(1, 4));
                q = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                do_write(a, q);
            end else if (kind == 2) begin
                // Partial byte: storage and model both untouched
                start_cs();
                hdr(8'h02, a);
                nib_tx(4'($urandom));
                end_cs();
            end else begin
                n = int'($urandom_range(1, 5));
                do_read($sformatf("rnd%0d", t), a, n, got);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] e;
                    e = mdl[8'(a + 24'(i))];
                    chk($sformatf("rnd%0d_b%0d_hi", t, i), 32'(got[2*i]), 32'(e[7:4]));
                    chk($sformatf("rnd%0d_b%0d_lo", t, i), 32'(got[2*i+1]), 32'(e[3:0]));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
